axi_addr_guard: RTL and testbench
=================================

Name: axi_addr_guard

Overview:
- AXI4 slave-to-master stage between the TLX master domain's AXI master port and the AxiSram memory in the test-SoC memory model.
- Forwards transactions whose start address falls inside the SRAM window.
- Terminates out-of-window transactions locally with DECERR, so a stray CGRA/host address cannot hang the TLX link.
- One outstanding transaction per direction; the read and write paths are independent.

Parameters:
- ID_WIDTH, 4: AXI ID width.
- DATA_WIDTH, 64: AXI data width; strobe width is DATA_WIDTH/8.
- ADDR_WIDTH, 32: AXI address width.
- MEM_ADDR_WIDTH, 27: the window is 2^MEM_ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000: window base; only bits [ADDR_WIDTH-1:MEM_ADDR_WIDTH] are compared.

Ports:
- ACLK  input  1  clock.
- ARESETn  input  1  asynchronous active-low reset.
- s_aw{id,addr,len,size,burst,valid}/s_awready  in/out  ID,ADDR,8,3,2,1/1  upstream write address.
- s_w{data,strb,last,valid}/s_wready  in/out  DATA,DATA/8,1,1/1  upstream write data.
- s_b{id,resp,valid}/s_bready  out/in  ID,2,1/1  upstream write response.
- s_ar{id,addr,len,size,burst,valid}/s_arready  in/out  ID,ADDR,8,3,2,1/1  upstream read address.
- s_r{id,data,resp,last,valid}/s_rready  out/in  ID,DATA,2,1,1/1  upstream read data.
- m_aw*/m_w*/m_b*/m_ar*/m_r*  mirrored  same widths  downstream (SRAM-side) channels.
- err_count  output  16  DECERR transaction count (optional feature).
- err_addr  output  ADDR_WIDTH  last rejected start address (optional feature).

Behaviour:
- Window hit: addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH]. Only the start address is checked; bursts crossing the window end are forwarded unchanged.
- Reset state: all valid/ready outputs are 0, all data/id/resp outputs are 0, write FSM is W_IDLE, read FSM is R_IDLE, beat counter is 0.
- Write FSM states: W_IDLE, W_PASS_DATA, W_PASS_RESP, W_ERR_DATA, W_ERR_RESP.
  - W_IDLE: s_awready=1. On AW handshake, latch id/len. A hit loads the m_aw register and moves to W_PASS_DATA; a miss moves to W_ERR_DATA.
  - W_PASS_DATA: m_awvalid is registered, asserted the cycle after s_aw handshake and held stable until m_awready. W is combinational: m_w*=s_w*, s_wready=m_wready. Exit to W_PASS_RESP once the WLAST handshake has occurred and AW has been accepted downstream, in either order.
  - W_PASS_RESP: B is combinational: s_b*=m_b*, m_bready=s_bready. Return to W_IDLE on the B handshake. m_bready=0 in every other state.
  - W_ERR_DATA: s_wready=1 and m_wvalid=0. Beats are discarded until WLAST; the beat count is not checked.
  - W_ERR_RESP: s_bvalid=1, s_bresp=2'b11, s_bid=latched id. Hold until s_bready, then go to W_IDLE.
- Read FSM states: R_IDLE, R_PASS_ADDR, R_PASS_DATA, R_ERR.
  - R_IDLE: s_arready=1. On AR handshake, latch id and len. A hit goes to R_PASS_ADDR (registered m_arvalid, next cycle, held until m_arready). A miss goes to R_ERR with beat counter=0.
  - R_PASS_DATA: R is combinational passthrough. Return to R_IDLE on the handshake carrying m_rlast.
  - R_ERR: first beat is valid the cycle after the AR handshake. s_rvalid=1, s_rdata=0, s_rresp=2'b11, s_rid=latched id, s_rlast=(counter==len). The counter increments on each s_rready handshake; go to R_IDLE after the last beat. len=255 yields 256 beats; the 8-bit counter must not wrap before RLAST.
- Minimum bubble: one idle cycle between transactions on each path (ready is low while busy).
- Simultaneous read and write: fully independent, no ordering between paths.
- Backpressure: all valid outputs and their payloads stay stable until the handshake completes.
- Mid-burst reset: both FSMs return to IDLE immediately. No response is owed for an interrupted transaction.

Optional Feature:
- Macro: AXI_ADDR_GUARD_ERRCNT_EN.
- Defined:
  - err_count increments by 1 on each missed AW or AR handshake and saturates at 16'hFFFF.
  - If both miss in the same cycle, it increments by 2, saturating.
  - err_addr latches the missed address; if both miss in the same cycle, AW wins.
  - Both reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- AW addr 0x0000_1000, len=3, then 4 W beats -> m_aw forwarded with identical fields one cycle later. 4 W beats pass through. SRAM B OKAY with id 5 reaches s_b.
- AW addr 0x0800_0000, id=2, len=3 -> m_awvalid stays 0. 4 W beats are accepted with s_wready=1. s_bresp=2'b11, bid=2. err_count=1, err_addr=0x0800_0000.
- AR addr 0xF000_0000, id=7, len=7, s_rready toggling 1/0 -> exactly 8 beats with rdata=0, rresp=3, rid=7. rlast only on beat 8. Payload is stable while stalled.
- AR len=255 miss -> 256 beats, rlast on beat 256. FSM returns to R_IDLE and s_arready=1 the next cycle.
- Same-cycle hit read at 0x100 and miss write at 0x1000_0000 -> read data comes from SRAM; write completes with DECERR; no interference between paths.
- ARESETn low during beat 3 of an error read -> s_rvalid=0 immediately. After release, s_arready=1 and err_count=0.

Source files
------------

// File: rtl/axi_addr_guard.sv
// AXI4 address guard: forwards in-window bursts to the SRAM, answers out-of-window ones with DECERR.
// Optional error counter and last-error address enabled by AXI_ADDR_GUARD_ERRCNT_EN.
module axi_addr_guard #(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 27,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // upstream write
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // upstream read
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // downstream write
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // downstream read
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // error statistics
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   err_addr
);

  typedef enum logic [2:0] {
    W_IDLE, W_PASS_DATA, W_PASS_RESP, W_ERR_DATA, W_ERR_RESP
  } wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_PASS_ADDR, R_PASS_DATA, R_ERR} rstate_e;

  wstate_e r_wstate, w_wstate_nxt;
  rstate_e r_rstate, w_rstate_nxt;

  // Holds the address-ready outputs low while reset is asserted.
  logic                  r_live;
  logic [ID_WIDTH-1:0]   r_bid, r_rid;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_wlast_seen;
  logic                  r_awvalid, r_arvalid;
  logic [ID_WIDTH-1:0]   r_awid, r_arid;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [7:0]            r_awlen, r_arlen;
  logic [2:0]            r_awsize, r_arsize;
  logic [1:0]            r_awburst, r_arburst;

  logic w_aw_hit, w_ar_hit, w_aw_hs, w_ar_hs, w_wpass_hs, w_aw_done, w_err_last;

  assign w_aw_hit = s_awaddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign w_ar_hit = s_araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign w_aw_hs    = s_awvalid && r_live && (r_wstate == W_IDLE);
  assign w_ar_hs    = s_arvalid && r_live && (r_rstate == R_IDLE);
  assign w_wpass_hs = (r_wstate == W_PASS_DATA) && !r_wlast_seen && s_wvalid && m_wready;
  assign w_aw_done  = !r_awvalid || m_awready;
  assign w_err_last = (r_rcnt == r_rlen);

  assign m_awvalid = r_awvalid;
  assign m_awid    = r_awid;
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = r_awsize;
  assign m_awburst = r_awburst;
  assign m_arvalid = r_arvalid;
  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = r_arburst;

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bid        = '0;
    s_bresp      = 2'b00;
    m_wdata      = '0;
    m_wstrb      = '0;
    m_wlast      = 1'b0;
    m_wvalid     = 1'b0;
    m_bready     = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        s_awready = r_live;
        if (w_aw_hs) w_wstate_nxt = w_aw_hit ? W_PASS_DATA : W_ERR_DATA;
      end
      W_PASS_DATA: begin
        if (!r_wlast_seen) begin
          m_wdata  = s_wdata;
          m_wstrb  = s_wstrb;
          m_wlast  = s_wlast;
          m_wvalid = s_wvalid;
          s_wready = m_wready;
        end
        // WLAST and the downstream AW handshake may complete in either order.
        if ((r_wlast_seen || (w_wpass_hs && s_wlast)) && w_aw_done) w_wstate_nxt = W_PASS_RESP;
      end
      W_PASS_RESP: begin
        s_bvalid = m_bvalid;
        s_bid    = m_bid;
        s_bresp  = m_bresp;
        m_bready = s_bready;
        if (m_bvalid && s_bready) w_wstate_nxt = W_IDLE;
      end
      W_ERR_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_wstate_nxt = W_ERR_RESP;
      end
      W_ERR_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b11;
        s_bid    = r_bid;
        if (s_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    s_rid        = '0;
    s_rdata      = '0;
    s_rresp      = 2'b00;
    s_rlast      = 1'b0;
    m_rready     = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        s_arready = r_live;
        if (w_ar_hs) w_rstate_nxt = w_ar_hit ? R_PASS_ADDR : R_ERR;
      end
      R_PASS_ADDR: if (m_arready) w_rstate_nxt = R_PASS_DATA;
      R_PASS_DATA: begin
        s_rvalid = m_rvalid;
        s_rid    = m_rid;
        s_rdata  = m_rdata;
        s_rresp  = m_rresp;
        s_rlast  = m_rlast;
        m_rready = s_rready;
        if (m_rvalid && s_rready && m_rlast) w_rstate_nxt = R_IDLE;
      end
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
        s_rid    = r_rid;
        s_rlast  = w_err_last;
        if (s_rready && w_err_last) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_live       <= 1'b0;
      r_wstate     <= W_IDLE;
      r_rstate     <= R_IDLE;
      r_bid        <= '0;
      r_rid        <= '0;
      r_rlen       <= '0;
      r_rcnt       <= '0;
      r_wlast_seen <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awsize     <= '0;
      r_awburst    <= '0;
      r_arvalid    <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
    end else begin
      r_live   <= 1'b1;
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;

      if (w_aw_hs) begin
        r_bid        <= s_awid;
        r_wlast_seen <= 1'b0;
        if (w_aw_hit) begin
          r_awvalid <= 1'b1;
          r_awid    <= s_awid;
          r_awaddr  <= s_awaddr;
          r_awlen   <= s_awlen;
          r_awsize  <= s_awsize;
          r_awburst <= s_awburst;
        end
      end else begin
        if (m_awready) r_awvalid <= 1'b0;
        if (w_wpass_hs && s_wlast) r_wlast_seen <= 1'b1;
      end

      if (w_ar_hs) begin
        r_rid  <= s_arid;
        r_rlen <= s_arlen;
        r_rcnt <= '0;
        if (w_ar_hit) begin
          r_arvalid <= 1'b1;
          r_arid    <= s_arid;
          r_araddr  <= s_araddr;
          r_arlen   <= s_arlen;
          r_arsize  <= s_arsize;
          r_arburst <= s_arburst;
        end
      end else begin
        if (m_arready) r_arvalid <= 1'b0;
        if (r_rstate == R_ERR && s_rready && !w_err_last) r_rcnt <= r_rcnt + 8'd1;
      end
    end
  end

`ifdef AXI_ADDR_GUARD_ERRCNT_EN
  logic                  w_aw_miss, w_ar_miss;
  logic [16:0]           w_err_sum;
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  assign w_aw_miss = w_aw_hs && !w_aw_hit;
  assign w_ar_miss = w_ar_hs && !w_ar_hit;
  assign w_err_sum = {1'b0, r_err_count} + 17'(w_aw_miss) + 17'(w_ar_miss);
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      if (w_aw_miss) r_err_addr <= s_awaddr;
      else if (w_ar_miss) r_err_addr <= s_araddr;
    end
  end
`else
  assign err_count = '0;
  assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_axi_addr_guard.sv
// Directed bench for axi_addr_guard: table of whole transactions plus concurrency and reset cases.
module tb_axi_addr_guard;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic [3:0]  s_awid = '0, s_arid = '0, s_bid, s_rid, m_awid, m_arid, m_bid = '0, m_rid = '0;
  logic [31:0] s_awaddr = '0, s_araddr = '0, m_awaddr, m_araddr, err_addr;
  logic [7:0]  s_awlen = '0, s_arlen = '0, m_awlen, m_arlen, s_wstrb = '0, m_wstrb;
  logic [2:0]  s_awsize = '0, s_arsize = '0, m_awsize, m_arsize;
  logic [1:0]  s_awburst = '0, s_arburst = '0, m_awburst, m_arburst;
  logic [1:0]  s_bresp, s_rresp, m_bresp = '0, m_rresp = '0;
  logic [63:0] s_wdata = '0, s_rdata, m_wdata, m_rdata = '0;
  logic        s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid;
  logic        s_bready = 0, s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 0;
  logic        m_awvalid, m_awready = 0, m_wlast, m_wvalid, m_wready = 0, m_bvalid = 0, m_bready;
  logic        m_arvalid, m_arready = 0, m_rlast = 0, m_rvalid = 0, m_rready;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_addr = '0;

  always #5 ACLK = ~ACLK;

  axi_addr_guard dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_count(err_count), .err_addr(err_addr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_err();
`ifdef AXI_ADDR_GUARD_ERRCNT_EN
    chk("err_count", 64'(err_count), 64'(exp_cnt));
    chk("err_addr", 64'(err_addr), 64'(exp_addr));
`else
    chk("err_count_tied", 64'(err_count), 64'd0);
    chk("err_addr_tied", 64'(err_addr), 64'd0);
`endif
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic hit);
    int n = 0;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd3; s_awburst = 2'd1;
    s_awvalid = 1;
    #1;
    while (!s_awready && n < 20) begin cyc(); n++; end
    chk("aw_ready", 64'(s_awready), 64'd1);
    cyc();
    s_awvalid = 0;
    if (hit) begin
      chk("m_awvalid", 64'(m_awvalid), 64'd1);
      chk("m_awfields", {16'(m_awid), m_awaddr, m_awlen, 5'(m_awsize), 3'(m_awburst)},
          {16'(id), addr, len, 5'd3, 3'd1});
      cyc();
      chk("m_awvalid_held", 64'(m_awvalid), 64'd1);
      chk("m_awaddr_held", 64'(m_awaddr), 64'(addr));
      m_awready = 1;
      cyc();
      m_awready = 0;
      chk("m_awvalid_drop", 64'(m_awvalid), 64'd0);
      m_wready = 1;
    end else begin
      chk("m_awvalid_miss", 64'(m_awvalid), 64'd0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      s_wvalid = 1; s_wdata = 64'hA5A5_0000_0000_0000 | 64'(b); s_wstrb = 8'hFF;
      s_wlast = (b == int'(len));
      #1;
      chk("s_wready", 64'(s_wready), 64'd1);
      if (hit) begin
        chk("m_wdata", m_wdata, 64'hA5A5_0000_0000_0000 | 64'(b));
        chk("m_wvalid_last", {62'd0, m_wvalid, m_wlast}, {62'd0, 1'b1, b == int'(len)});
      end else begin
        chk("m_wvalid_miss", 64'(m_wvalid), 64'd0);
      end
      cyc();
    end
    s_wvalid = 0; s_wlast = 0; m_wready = 0;
    if (hit) begin
      m_bvalid = 1; m_bid = id; m_bresp = 2'b00; s_bready = 0;
      #1;
      chk("s_b_pass", {56'd0, s_bvalid, s_bid, s_bresp, m_bready}, {56'd0, 1'b1, id, 2'b00, 1'b0});
      s_bready = 1;
      #1;
      chk("m_bready", 64'(m_bready), 64'd1);
      cyc();
      m_bvalid = 0;
    end else begin
      chk("s_b_err", {57'd0, s_bvalid, s_bid, s_bresp}, {57'd0, 1'b1, id, 2'b11});
      cyc();
      chk("s_b_err_held", {57'd0, s_bvalid, s_bid, s_bresp}, {57'd0, 1'b1, id, 2'b11});
      s_bready = 1;
      cyc();
    end
    s_bready = 0;
    #1;
    chk("s_bvalid_done", 64'(s_bvalid), 64'd0);
    chk("aw_ready_idle", 64'(s_awready), 64'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic hit, input logic tog);
    int n = 0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = 2'd1;
    s_arvalid = 1;
    #1;
    while (!s_arready && n < 20) begin cyc(); n++; end
    chk("ar_ready", 64'(s_arready), 64'd1);
    cyc();
    s_arvalid = 0;
    if (hit) begin
      chk("m_arfields", {15'(m_arvalid), 4'(m_arid), m_araddr, m_arlen, 5'(m_arsize)},
          {15'd1, id, addr, len, 5'd3});
      m_arready = 1;
      cyc();
      m_arready = 0;
      chk("m_arvalid_drop", 64'(m_arvalid), 64'd0);
      for (int b = 0; b <= int'(len); b++) begin
        m_rvalid = 1; m_rdata = 64'hDEAD_0000_0000_0000 + 64'(b); m_rid = id; m_rresp = 2'b00;
        m_rlast = (b == int'(len)); s_rready = 1;
        #1;
        chk("s_rdata_pass", s_rdata, 64'hDEAD_0000_0000_0000 + 64'(b));
        chk("s_r_pass", {56'd0, s_rvalid, s_rid, s_rlast, m_rready},
            {56'd0, 1'b1, id, b == int'(len), 1'b1});
        cyc();
      end
      m_rvalid = 0; m_rlast = 0;
    end else begin
      chk("m_arvalid_miss", 64'(m_arvalid), 64'd0);
      for (int b = 0; b <= int'(len); b++) begin
        if (tog && b[0]) begin
          s_rready = 0;
          cyc();
          chk("r_err_stall", {56'd0, s_rvalid, s_rid, s_rresp, s_rlast},
              {56'd0, 1'b1, id, 2'b11, b == int'(len)});
        end
        s_rready = 1;
        #1;
        chk("s_rdata_err", s_rdata, 64'd0);
        chk("r_err", {56'd0, s_rvalid, s_rid, s_rresp, s_rlast},
            {56'd0, 1'b1, id, 2'b11, b == int'(len)});
        cyc();
      end
    end
    s_rready = 0;
    #1;
    chk("s_rvalid_done", 64'(s_rvalid), 64'd0);
    chk("ar_ready_idle", 64'(s_arready), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        hit;
    logic        tog;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 4'h5, 32'h0000_1000, 8'd3,   1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'h2, 32'h0800_0000, 8'd3,   1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'h7, 32'hF000_0000, 8'd7,   1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'h3, 32'h0000_0100, 8'd1,   1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'hA, 32'h07FF_FFF0, 8'd0,   1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'h1, 32'h0800_0000, 8'd0,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'hF, 32'h1234_0000, 8'd255, 1'b0, 1'b0};

    cyc(); cyc();
    chk("rst_ready", {60'd0, s_awready, s_arready, s_wready, m_bready}, 64'd0);
    chk("rst_valid", {59'd0, m_awvalid, m_arvalid, s_bvalid, s_rvalid, m_wvalid}, 64'd0);
    chk("rst_payload", {48'd0, 4'(m_awid), 4'(s_bid), 4'(s_rid), 2'(s_bresp), 2'(s_rresp)}, 64'd0);
    chk_err();
    ARESETn = 1;
    cyc(); cyc();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].hit);
      else do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].hit, vecs[i].tog);
      if (!vecs[i].hit) begin
        exp_cnt++;
        exp_addr = vecs[i].addr;
      end
      chk_err();
      cyc();
    end

    // Read hit and write miss in the same cycle.
    fork
      do_read(4'h4, 32'h0000_0100, 8'd2, 1'b1, 1'b0);
      do_write(4'h6, 32'h1000_0000, 8'd1, 1'b0);
    join
    exp_cnt++;
    exp_addr = 32'h1000_0000;
    chk_err();
    cyc();

    // Both paths miss in the same cycle: count +2, AW address retained.
    fork
      do_read(4'h8, 32'h2000_0000, 8'd0, 1'b0, 1'b0);
      do_write(4'h9, 32'h3000_0000, 8'd0, 1'b0);
    join
    exp_cnt += 2;
    exp_addr = 32'h3000_0000;
    chk_err();
    cyc();

    // Reset asserted during beat 3 of an error read.
    s_arid = 4'h9; s_araddr = 32'hE000_0000; s_arlen = 8'd7; s_arvalid = 1;
    #1;
    chk("rst_seq_arready", 64'(s_arready), 64'd1);
    cyc();
    s_arvalid = 0;
    s_rready = 1;
    cyc(); cyc();
    s_rready = 0;
    chk("rst_seq_beat3", {59'd0, s_rvalid, s_rid}, {59'd0, 1'b1, 4'h9});
    ARESETn = 0;
    #1;
    chk("rst_mid_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_mid_arready", 64'(s_arready), 64'd0);
    cyc();
    ARESETn = 1;
    cyc(); cyc();
    exp_cnt = 0;
    exp_addr = '0;
    chk("rst_after_arready", 64'(s_arready), 64'd1);
    chk("rst_after_rvalid", 64'(s_rvalid), 64'd0);
    chk_err();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
